// File: rtl/sa_pkg.sv
// ============================================================================
// sa_pkg : shared sizes and drain FSM encoding for the systolic-array tile
// Revision 1.0
// ============================================================================
`default_nettype none

package sa_pkg;

    localparam int SA_DIM    = 8;
    localparam int SA_ACC_W  = 19;
    localparam int SA_OUT_W  = 8;
    localparam int SA_LANES  = 16;
    localparam int SA_BEATS  = SA_DIM * SA_DIM / SA_LANES;
    localparam int SA_BEAT_W = $clog2(SA_BEATS);

    typedef enum logic [0:0] {
        DRN_IDLE = 1'b0,
        DRN_SEND = 1'b1
    } drn_state_e;

endpackage

`default_nettype wire

// File: rtl/sa_requant.sv
// ============================================================================
// sa_requant : rounding arithmetic right shift of one accumulator, saturated
// Revision 1.0
// ============================================================================
`default_nettype none

module sa_requant
    import sa_pkg::*;
#(
    parameter int ACC_W = SA_ACC_W,
    parameter int OUT_W = SA_OUT_W
) (
    input  logic [ACC_W-1:0] y,
    input  logic [3:0]       shift,
    output logic [OUT_W-1:0] q
);

    // One guard bit keeps the rounding add from overflowing at the positive rail.
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] Q_MIN = SUM_W'(-(1 << (OUT_W - 1)));

    logic signed [SUM_W-1:0] y_ext;
    logic signed [SUM_W-1:0] rnd;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shr;

    always_comb begin
        y_ext = {y[ACC_W-1], y};
        rnd   = (shift == 4'd0) ? '0 : (SUM_W'(1) << (shift - 4'd1));
        sum   = y_ext + rnd;
        shr   = sum >>> shift;
        if (shr > Q_MAX) begin
            q = Q_MAX[OUT_W-1:0];
        end else if (shr < Q_MIN) begin
            q = Q_MIN[OUT_W-1:0];
        end else begin
            q = shr[OUT_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sa_result_drain.sv
// ============================================================================
// sa_result_drain : captures the 8x8 result matrix, requantizes, streams 4 beats
// Revision 1.0
// ============================================================================
`default_nettype none

module sa_result_drain
    import sa_pkg::*;
#(
    parameter int DIM   = SA_DIM,
    parameter int ACC_W = SA_ACC_W,
    parameter int OUT_W = SA_OUT_W,
    parameter int LANES = SA_LANES
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic [DIM*DIM*ACC_W-1:0]     Y_FLAT,
    input  logic                         Y_VALID,
    input  logic [3:0]                   SHIFT,
    output logic [LANES*OUT_W-1:0]       DOUT,
    output logic [$clog2(DIM*DIM/LANES)-1:0] DOUT_IDX,
    output logic                         DOUT_VALID,
    input  logic                         DOUT_READY,
    output logic                         DONE,
    output logic                         OVERRUN,
    output logic                         BUSY
);

    localparam int BEATS     = DIM * DIM / LANES;
    localparam int BEAT_W    = $clog2(BEATS);
    localparam int MAT_W     = DIM * DIM * ACC_W;
    localparam int BEAT_BITS = LANES * ACC_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    drn_state_e         state_q,   state_d;
    logic [BEAT_W-1:0]  beat_q,    beat_d;
    logic [MAT_W-1:0]   buf_q,     buf_d;
    logic [3:0]         shift_q,   shift_d;
    logic               done_q,    done_d;
    logic               overrun_q, overrun_d;
    logic               capture;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= DRN_IDLE;
            beat_q    <= '0;
            buf_q     <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            buf_q     <= buf_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // With EN low every _d equals its _q, so the whole block freezes.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        buf_d     = buf_q;
        shift_d   = shift_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        capture   = 1'b0;

        if (EN) begin
            done_d = 1'b0;
            case (state_q)
                DRN_IDLE: begin
                    if (Y_VALID) begin
                        capture = 1'b1;
                    end
                end
                DRN_SEND: begin
                    if (DOUT_READY) begin
                        if (beat_q == LAST_BEAT) begin
                            done_d = 1'b1;
                            // A new matrix arriving with the final accept is taken without a bubble.
                            if (Y_VALID) begin
                                capture = 1'b1;
                            end else begin
                                state_d = DRN_IDLE;
                                beat_d  = '0;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                            if (Y_VALID) begin
                                overrun_d = 1'b1;
                            end
                        end
                    end else if (Y_VALID) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = DRN_IDLE;
                    beat_d  = '0;
                end
            endcase

            if (capture) begin
                buf_d   = Y_FLAT;
                shift_d = SHIFT;
                beat_d  = '0;
                state_d = DRN_SEND;
            end
        end
    end

    logic                   send;
    logic [BEAT_BITS-1:0]   beat_row;
    logic [LANES*OUT_W-1:0] lane_q;

    assign send     = (state_q == DRN_SEND);
    // Rows 2b and 2b+1 are contiguous in the flat buffer.
    assign beat_row = buf_q[beat_q*BEAT_BITS +: BEAT_BITS];

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            sa_requant #(
                .ACC_W (ACC_W),
                .OUT_W (OUT_W)
            ) u_requant (
                .y     (beat_row[k*ACC_W +: ACC_W]),
                .shift (shift_q),
                .q     (lane_q[k*OUT_W +: OUT_W])
            );
        end
    endgenerate

    assign DOUT       = send ? lane_q : '0;
    assign DOUT_IDX   = send ? beat_q : '0;
    assign DOUT_VALID = send;
    assign BUSY       = send;
    assign DONE       = done_q;
    assign OVERRUN    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sa_result_drain.sv
// ============================================================================
// tb_sa_result_drain : scoreboard bench for the result drain
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sa_result_drain;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           EN = 1'b1;
    logic [1215:0]  Y_FLAT = '0;
    logic           Y_VALID = 1'b0;
    logic [3:0]     SHIFT = 4'd0;
    logic [127:0]   DOUT;
    logic [1:0]     DOUT_IDX;
    logic           DOUT_VALID;
    logic           DOUT_READY = 1'b0;
    logic           DONE;
    logic           OVERRUN;
    logic           BUSY;

    sa_result_drain dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .Y_FLAT     (Y_FLAT),
        .Y_VALID    (Y_VALID),
        .SHIFT      (SHIFT),
        .DOUT       (DOUT),
        .DOUT_IDX   (DOUT_IDX),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .DONE       (DONE),
        .OVERRUN    (OVERRUN),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   idx;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    accepted = 0;
    int    mat[64];

    // Reference: floor((y + half) / 2^sh), saturated to int8.
    function automatic logic [7:0] q8(int y, int sh);
        int rnd;
        int s;
        int d;
        int q;
        rnd = (sh > 0) ? (1 << (sh - 1)) : 0;
        s   = y + rnd;
        d   = 1 << sh;
        if (s >= 0) q = s / d;
        else        q = -((-s + d - 1) / d);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic push_expected(int sh);
        for (int b = 0; b < 4; b++) begin
            beat_t e;
            e.idx  = b[1:0];
            e.data = '0;
            for (int k = 0; k < 16; k++) e.data[8*k +: 8] = q8(mat[16*b + k], sh);
            sb.push_back(e);
        end
    endtask

    task automatic load_y;
        for (int i = 0; i < 64; i++) Y_FLAT[i*19 +: 19] = mat[i][18:0];
    endtask

    task automatic clear_mat;
        for (int i = 0; i < 64; i++) mat[i] = 0;
    endtask

    task automatic rand_mat;
        for (int i = 0; i < 64; i++) mat[i] = int'($urandom_range(0, 524287)) - 262144;
    endtask

    // Advance one cycle; accepted beats are popped and compared at the falling edge.
    task automatic tick;
        beat_t e;
        @(negedge CLK);
        if (RST && EN && DOUT_VALID && DOUT_READY) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: idx %0d data %h, none expected", DOUT_IDX, DOUT);
            end else begin
                e = sb.pop_front();
                if (DOUT !== e.data || DOUT_IDX !== e.idx) begin
                    failures++;
                    $display("FAIL beat_data: got idx %0d data %h, want idx %0d data %h",
                             DOUT_IDX, DOUT, e.idx, e.data);
                end
            end
            accepted++;
        end
        @(posedge CLK);
        #1;
    endtask

    // Drive one capture strobe; returns with beat 0 on the outputs.
    task automatic start(int sh);
        load_y();
        SHIFT   = sh[3:0];
        Y_VALID = 1'b1;
        push_expected(sh);
        tick();
        Y_VALID = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while (DONE !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (DONE !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout: DONE=%b after %0d cycles, want 1", name, DONE, n);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0; EN = 1'b1; DOUT_READY = 1'b0;
        tick(); tick();
        checks += 6;
        if (DOUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", DOUT_VALID); end
        if (BUSY !== 1'b0)       begin failures++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        if (DONE !== 1'b0)       begin failures++; $display("FAIL rst_done: got %b want 0", DONE); end
        if (OVERRUN !== 1'b0)    begin failures++; $display("FAIL rst_overrun: got %b want 0", OVERRUN); end
        if (DOUT !== 128'd0)     begin failures++; $display("FAIL rst_dout: got %h want 0", DOUT); end
        if (DOUT_IDX !== 2'd0)   begin failures++; $display("FAIL rst_idx: got %0d want 0", DOUT_IDX); end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        clear_mat();
        mat[0]  = 100;
        mat[63] = -5;
        DOUT_READY = 1'b1;
        start(0);
        checks += 3;
        if (DOUT_VALID !== 1'b1)   begin failures++; $display("FAIL basic_latency: valid %b want 1", DOUT_VALID); end
        if (DOUT_IDX !== 2'd0)     begin failures++; $display("FAIL basic_idx0: got %0d want 0", DOUT_IDX); end
        if (DOUT[7:0] !== 8'h64)   begin failures++; $display("FAIL basic_lane0: got %h want 64", DOUT[7:0]); end
        for (int b = 1; b < 4; b++) begin
            tick();
            checks++;
            if (DOUT_IDX !== b[1:0] || DOUT_VALID !== 1'b1) begin
                failures++;
                $display("FAIL basic_seq: idx %0d valid %b want idx %0d valid 1", DOUT_IDX, DOUT_VALID, b);
            end
        end
        checks += 2;
        if (DOUT[127:120] !== 8'hFB) begin failures++; $display("FAIL basic_lane15: got %h want fb", DOUT[127:120]); end
        if (DONE !== 1'b0)           begin failures++; $display("FAIL basic_early_done: got %b want 0", DONE); end
        tick();
        checks += 3;
        if (DONE !== 1'b1)       begin failures++; $display("FAIL basic_done: got %b want 1", DONE); end
        if (DOUT_VALID !== 1'b0) begin failures++; $display("FAIL basic_idle_valid: got %b want 0", DOUT_VALID); end
        if (BUSY !== 1'b0)       begin failures++; $display("FAIL basic_idle_busy: got %b want 0", BUSY); end
        tick();
        checks += 2;
        if (DONE !== 1'b0)   begin failures++; $display("FAIL basic_done_pulse: got %b want 0", DONE); end
        if (sb.size() != 0)  begin failures++; $display("FAIL basic_sb: %0d beats left want 0", sb.size()); end
    endtask

    task automatic test_requant;
        clear_mat();
        mat[0] = 24; mat[1] = 23; mat[2] = -24; mat[3] = -25;
        start(4);
        checks++;
        if (DOUT[31:0] !== 32'hFEFF0102) begin
            failures++;
            $display("FAIL requant_lanes: got %h want feff0102", DOUT[31:0]);
        end
        wait_done("requant");
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL requant_sb: %0d left want 0", sb.size()); end
    endtask

    task automatic test_saturation;
        clear_mat();
        mat[0] = 300; mat[1] = -300; mat[2] = 262143; mat[3] = -262144;
        start(0);
        checks++;
        if (DOUT[31:0] !== 32'h807F807F) begin
            failures++;
            $display("FAIL sat_lanes: got %h want 807f807f", DOUT[31:0]);
        end
        wait_done("sat");
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sat_sb: %0d left want 0", sb.size()); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            int n = 0;
            rand_mat();
            DOUT_READY = 1'b1;
            start(int'($urandom_range(0, 15)));
            while (DONE !== 1'b1 && n < 80) begin
                DOUT_READY = $urandom_range(0, 1) == 1;
                tick();
                n++;
            end
            DOUT_READY = 1'b1;
            checks += 2;
            if (DONE !== 1'b1)  begin failures++; $display("FAIL random_done: iter %0d DONE %b want 1", it, DONE); end
            if (sb.size() != 0) begin failures++; $display("FAIL random_sb: iter %0d %0d left want 0", it, sb.size()); end
        end
        tick();
    endtask

    task automatic test_backpressure;
        logic [127:0] saved;
        int           acc0;
        rand_mat();
        DOUT_READY = 1'b1;
        acc0 = accepted;
        start(3);
        tick();
        DOUT_READY = 1'b0;
        saved = DOUT;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (DOUT_IDX !== 2'd1 || DOUT !== saved || DOUT_VALID !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold: idx %0d valid %b data %h want idx 1 valid 1 data %h",
                         DOUT_IDX, DOUT_VALID, DOUT, saved);
            end
        end
        DOUT_READY = 1'b1;
        tick();
        checks++;
        if (DOUT_IDX !== 2'd2) begin failures++; $display("FAIL bp_resume: idx %0d want 2", DOUT_IDX); end
        wait_done("bp");
        checks += 2;
        if (accepted - acc0 != 4) begin failures++; $display("FAIL bp_count: %0d beats want 4", accepted - acc0); end
        if (sb.size() != 0)       begin failures++; $display("FAIL bp_sb: %0d left want 0", sb.size()); end
        tick();
    endtask

    task automatic test_back_to_back;
        rand_mat();
        DOUT_READY = 1'b1;
        start(2);
        tick(); tick(); tick();
        rand_mat();
        load_y();
        SHIFT   = 4'd5;
        Y_VALID = 1'b1;
        push_expected(5);
        tick();
        Y_VALID = 1'b0;
        SHIFT   = 4'd0;
        checks += 4;
        if (DONE !== 1'b1)                         begin failures++; $display("FAIL b2b_done: got %b want 1", DONE); end
        if (DOUT_VALID !== 1'b1 || BUSY !== 1'b1)  begin failures++; $display("FAIL b2b_busy: valid %b busy %b want 1 1", DOUT_VALID, BUSY); end
        if (DOUT_IDX !== 2'd0)                     begin failures++; $display("FAIL b2b_idx: got %0d want 0", DOUT_IDX); end
        if (OVERRUN !== 1'b0)                      begin failures++; $display("FAIL b2b_overrun: got %b want 0", OVERRUN); end
        tick();
        wait_done("b2b");
        checks += 2;
        if (sb.size() != 0)   begin failures++; $display("FAIL b2b_sb: %0d left want 0", sb.size()); end
        if (OVERRUN !== 1'b0) begin failures++; $display("FAIL b2b_overrun_end: got %b want 0", OVERRUN); end
        tick();
    endtask

    task automatic test_en_freeze;
        logic [127:0] saved;
        rand_mat();
        DOUT_READY = 1'b1;
        start(1);
        tick(); tick();
        EN = 1'b0;
        saved = DOUT;
        rand_mat();
        load_y();
        Y_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (DOUT_IDX !== 2'd2 || DOUT !== saved || DOUT_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
                failures++;
                $display("FAIL en_freeze: idx %0d valid %b ovr %b data %h want idx 2 valid 1 ovr 0 data %h",
                         DOUT_IDX, DOUT_VALID, OVERRUN, DOUT, saved);
            end
        end
        Y_VALID = 1'b0;
        EN = 1'b1;
        wait_done("en");
        checks += 2;
        if (sb.size() != 0)   begin failures++; $display("FAIL en_sb: %0d left want 0", sb.size()); end
        if (OVERRUN !== 1'b0) begin failures++; $display("FAIL en_overrun: got %b want 0", OVERRUN); end
        tick();
    endtask

    task automatic test_overrun;
        rand_mat();
        DOUT_READY = 1'b1;
        start(0);
        tick();
        rand_mat();
        load_y();
        Y_VALID = 1'b1;
        tick();
        Y_VALID = 1'b0;
        checks += 2;
        if (OVERRUN !== 1'b1)  begin failures++; $display("FAIL ovr_set: got %b want 1", OVERRUN); end
        if (DOUT_IDX !== 2'd2) begin failures++; $display("FAIL ovr_stream: idx %0d want 2", DOUT_IDX); end
        wait_done("ovr");
        tick();
        checks += 3;
        if (sb.size() != 0)      begin failures++; $display("FAIL ovr_sb: %0d left want 0", sb.size()); end
        if (OVERRUN !== 1'b1)    begin failures++; $display("FAIL ovr_sticky: got %b want 1", OVERRUN); end
        if (DOUT_VALID !== 1'b0) begin failures++; $display("FAIL ovr_no_restart: valid %b want 0", DOUT_VALID); end
    endtask

    task automatic test_reset_mid;
        rand_mat();
        DOUT_READY = 1'b1;
        start(2);
        tick();
        RST = 1'b0;
        tick();
        checks += 4;
        if (DOUT_VALID !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", DOUT_VALID); end
        if (BUSY !== 1'b0)       begin failures++; $display("FAIL rmid_busy: got %b want 0", BUSY); end
        if (OVERRUN !== 1'b0)    begin failures++; $display("FAIL rmid_overrun: got %b want 0", OVERRUN); end
        if (DONE !== 1'b0)       begin failures++; $display("FAIL rmid_done: got %b want 0", DONE); end
        RST = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (DONE !== 1'b0 || DOUT_VALID !== 1'b0) begin
                failures++;
                $display("FAIL rmid_after: done %b valid %b want 0 0", DONE, DOUT_VALID);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_requant();
        test_saturation();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_en_freeze();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
